// File: rtl/morse_pkg.sv
// Shared Morse definitions for the LED driver and receive decoder.
// Timing is expressed in Morse units; scaling to cycles happens at use.
package morse_pkg;

  localparam int MORSE_CODE_W   = 8;
  localparam int MORSE_LEN_W    = 4;

  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS = 7;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    GAP,
    WORD,
    DISCARD
  } morse_rx_state_t;

endpackage

// File: rtl/morse_run_cnt.sv
// Saturating run-length counter with synchronous clear.
// Counts cycles while inc is high, holding at SAT.
module morse_run_cnt #(
  parameter int W   = 4,
  parameter int SAT = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] SAT_V = W'(SAT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != SAT_V) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receive decoder: turns the LED on/off stream back into
// MSB-first symbol codes, word-gap markers and timing errors.
module morse_rx_decoder
  import morse_pkg::*;
#(
  parameter int UNIT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    led_drv,
  output logic                    code_vald,
  output logic [MORSE_CODE_W-1:0] code_data,
  output logic [MORSE_LEN_W-1:0]  code_len,
  output logic                    code_err
);

  localparam int CNT_W = $clog2(WORD_GAP_UNITS*UNIT+1);

  localparam logic [CNT_W-1:0] DOT_C  =
    CNT_W'(DOT_UNITS*UNIT);
  localparam logic [CNT_W-1:0] DASH_C =
    CNT_W'(DASH_UNITS*UNIT);
  // Thresholds minus one: the edge that samples the final 0
  // still sees the count before that 0 is added.
  localparam logic [CNT_W-1:0] CHR_M1 =
    CNT_W'(CHAR_GAP_UNITS*UNIT-1);
  localparam logic [CNT_W-1:0] WRD_M1 =
    CNT_W'(WORD_GAP_UNITS*UNIT-1);

  localparam logic [MORSE_LEN_W-1:0] MAX_SYM =
    MORSE_LEN_W'(MORSE_CODE_W);

  morse_rx_state_t state, state_n;

  logic [CNT_W-1:0]        on_cnt;
  logic [CNT_W-1:0]        off_cnt;
  logic [MORSE_CODE_W-1:0] shreg, shreg_n;
  logic [MORSE_LEN_W-1:0]  sym_cnt, sym_n;
  logic                    emit_chr;
  logic                    emit_spc;
  logic                    err;

  morse_run_cnt #(
    .W   (CNT_W),
    .SAT (4*UNIT)
  ) u_on_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (!led_drv),
    .inc   (led_drv),
    .cnt   (on_cnt)
  );

  morse_run_cnt #(
    .W   (CNT_W),
    .SAT (WORD_GAP_UNITS*UNIT)
  ) u_off_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (led_drv),
    .inc   (!led_drv),
    .cnt   (off_cnt)
  );

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    sym_n    = sym_cnt;
    emit_chr = 1'b0;
    emit_spc = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (led_drv) state_n = MARK;
      end
      MARK: begin
        if (!led_drv) begin
          if ((on_cnt == DOT_C || on_cnt == DASH_C) &&
              sym_cnt != MAX_SYM) begin
            shreg_n[~sym_cnt[2:0]] = (on_cnt == DASH_C);
            sym_n   = sym_cnt + MORSE_LEN_W'(1);
            state_n = GAP;
          end else begin
            err     = 1'b1;
            shreg_n = '0;
            sym_n   = '0;
            state_n = DISCARD;
          end
        end
      end
      GAP: begin
        if (led_drv) begin
          state_n = MARK;
        end else if (off_cnt == CHR_M1) begin
          emit_chr = 1'b1;
          shreg_n  = '0;
          sym_n    = '0;
          state_n  = WORD;
        end
      end
      WORD: begin
        if (led_drv) begin
          state_n = MARK;
        end else if (off_cnt == WRD_M1) begin
          emit_spc = 1'b1;
          state_n  = IDLE;
        end
      end
      DISCARD: begin
        shreg_n = '0;
        sym_n   = '0;
        if (!led_drv && off_cnt >= CHR_M1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      sym_cnt   <= '0;
      code_vald <= 1'b0;
      code_err  <= 1'b0;
      code_data <= '0;
      code_len  <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      sym_cnt   <= sym_n;
      code_vald <= emit_chr | emit_spc;
      code_err  <= err;
      if (emit_chr) begin
        code_data <= shreg;
        code_len  <= sym_cnt;
      end else if (emit_spc) begin
        code_data <= '0;
        code_len  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Bench for morse_rx_decoder: directed cases, driver-format loopback
// and random run lengths against a run-length reference model.
module tb_morse_rx_decoder;

  localparam int U = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       led_drv;
  logic       code_vald;
  logic       code_err;
  logic [7:0] code_data;
  logic [3:0] code_len;

  always #5 clock = ~clock;

  morse_rx_decoder #(.UNIT(U)) dut (
    .clock     (clock),
    .reset     (reset),
    .led_drv   (led_drv),
    .code_vald (code_vald),
    .code_data (code_data),
    .code_len  (code_len),
    .code_err  (code_err)
  );

  int checks = 0;
  int errors = 0;

  int   run0, run1;
  bit   armed, disc;
  bit   syms[$];
  bit   e_vald, e_err;
  logic [7:0] e_data;
  logic [3:0] e_len;

  int   n_chr, n_spc, n_err;
  logic [7:0] last_data;
  logic [3:0] last_len;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run0 = 0;
    run1 = 0;
    armed = 0;
    disc = 0;
    syms.delete();
    e_vald = 0;
    e_err = 0;
    e_data = '0;
    e_len = '0;
  endtask

  // One sample of the LED stream, in terms of runs of 1s and 0s.
  task automatic model_step(bit s);
    e_vald = 0;
    e_err = 0;
    if (s) begin
      run1++;
      run0 = 0;
      armed = 0;
    end else begin
      if (run1 > 0) begin
        if (!disc) begin
          if ((run1 == U || run1 == 3*U) && syms.size() < 8) begin
            syms.push_back(run1 == 3*U);
          end else begin
            e_err = 1;
            disc = 1;
            syms.delete();
          end
        end
        run1 = 0;
      end
      run0++;
      if (run0 == 3*U) begin
        if (disc) begin
          disc = 0;
        end else if (syms.size() > 0) begin
          e_vald = 1;
          e_data = '0;
          foreach (syms[i]) e_data[7-i] = syms[i];
          e_len = 4'(syms.size());
          syms.delete();
          armed = 1;
        end
      end else if (run0 == 7*U && armed) begin
        e_vald = 1;
        e_data = '0;
        e_len = '0;
        armed = 0;
      end
    end
  endtask

  task automatic compare_outs();
    check("vald", code_vald, e_vald);
    check("err", code_err, e_err);
    check("data", code_data, e_data);
    check("len", code_len, e_len);
    if (code_vald) begin
      if (code_len == 0) n_spc++;
      else begin
        n_chr++;
        last_data = code_data;
        last_len = code_len;
      end
    end
    if (code_err) n_err++;
  endtask

  task automatic step(bit s);
    @(negedge clock);
    reset = 1'b0;
    led_drv = s;
    @(posedge clock);
    model_step(s);
    #1;
    compare_outs();
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    led_drv = 1'b0;
    @(posedge clock);
    model_reset();
    #1;
    compare_outs();
  endtask

  task automatic mark(int n);
    repeat (n) step(1'b1);
  endtask

  task automatic gap(int n);
    repeat (n) step(1'b0);
  endtask

  task automatic send_char(string p);
    for (int j = 0; j < p.len(); j++) begin
      mark(p[j] == "-" ? 3*U : U);
      if (j < p.len() - 1) gap(U);
    end
  endtask

  function automatic string morse_of(byte c);
    case (c)
      "M":     return "--";
      "1":     return ".----";
      "6":     return "-....";
      "T":     return "-";
      "A":     return ".-";
      "F":     return "..-.";
      "I":     return "..";
      default: return ".";
    endcase
  endfunction

  task automatic clear_counts();
    n_chr = 0;
    n_spc = 0;
    n_err = 0;
  endtask

  initial begin
    string msg;
    int    len, r, ml;
    msg = "M16 TA FATIMA";
    clear_counts();
    last_data = '0;
    last_len = '0;

    reset = 1'b1;
    led_drv = 1'b0;
    repeat (2) @(posedge clock);
    model_reset();
    #1;
    compare_outs();

    gap(10*U);
    check("idle_quiet", n_chr + n_spc + n_err, 0);

    // 'M', then the rest of a long word gap
    send_char("--");
    gap(3*U);
    check("m_data", last_data, 8'hC0);
    check("m_len", last_len, 4'd2);
    gap(4*U);
    check("m_space", n_spc, 1);
    gap(20);
    check("one_space", n_spc, 1);

    // Malformed mark, then 'E'
    clear_counts();
    mark(2*U);
    gap(3*U);
    check("bad_err", n_err, 1);
    check("bad_nochr", n_chr, 0);
    send_char(".");
    gap(3*U);
    check("e_data", last_data, 8'h00);
    check("e_len", last_len, 4'd1);
    gap(7*U);

    // Nine dots overflow the code word
    clear_counts();
    send_char(".........");
    gap(3*U);
    check("ovf_err", n_err, 1);
    check("ovf_nochr", n_chr, 0);
    gap(7*U);

    // Reset in the middle of 'M'
    clear_counts();
    mark(3*U);
    gap(U);
    pulse_reset();
    gap(8*U);
    check("rst_quiet", n_chr + n_spc + n_err, 0);
    send_char(".-");
    gap(3*U);
    check("a_data", last_data, 8'h40);
    check("a_len", last_len, 4'd2);
    gap(7*U);

    // Loopback in the driver's stream format
    clear_counts();
    for (int i = 0; i < msg.len(); i++) begin
      if (msg[i] != " ") begin
        send_char(morse_of(msg[i]));
        if (i + 1 < msg.len() && msg[i+1] == " ") gap(7*U);
        else gap(3*U);
      end
    end
    check("lb_chars", n_chr, 11);
    check("lb_spaces", n_spc, 2);
    check("lb_errs", n_err, 0);
    gap(7*U);

    // Random mark/space run lengths
    repeat (150) begin
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        ml = (r < 4) ? U : (r < 8) ? 3*U : $urandom_range(1, 5*U);
        mark(ml);
        if (k < len - 1) begin
          if ($urandom_range(0, 5) != 0) gap(U);
          else gap($urandom_range(1, 3*U - 1));
        end
      end
      case ($urandom_range(0, 3))
        0:       gap(3*U);
        1:       gap(7*U);
        2:       gap($urandom_range(3*U, 6*U));
        default: gap($urandom_range(1, 10*U));
      endcase
      if ($urandom_range(0, 40) == 0) pulse_reset();
    end
    gap(10*U);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
